// File: rtl/tsr_host_bridge.sv
// tsr_host_bridge: host bus front end for the traffic-sign core.
// Pixel packing, weight streaming, soft reset, result and cycle count.
module tsr_host_bridge #(
   parameter int IN_WIDTH          = 32,
   parameter int IN_HEIGHT         = 32,
   parameter int CHANNELS          = 3,
   parameter int NUM_WEIGHTS       = 56690,
   parameter int OUT_BITS          = 6,
   parameter int SOFT_RESET_CYCLES = 15,
   parameter int AXI_ADDR_WIDTH    = 20,
   parameter int CNT_ADDR          = 'h9_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      axi_wr_en,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
   input  logic [63:0]               axi_wr_data,
   input  logic [7:0]                axi_wr_strobe,
   output logic                      axi_wr_ready,
   input  logic                      axi_rd_en,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
   output logic [63:0]               axi_rd_data,
   output logic                      model_rst_n,
   output logic [8*CHANNELS-1:0]     pix_data,
   output logic                      pix_valid,
   input  logic                      pix_ready,
   output logic [15:0]               weight_wr_data,
   output logic [31:0]               weight_wr_addr,
   output logic                      weight_wr_en,
   input  logic                      model_o_valid,
   input  logic [OUT_BITS-1:0]       model_o_data,
   output logic                      o_valid,
   output logic [OUT_BITS-1:0]       o_data,
   output logic                      busy,
   output logic                      weight_load_done
);

   localparam int FB   = IN_WIDTH * IN_HEIGHT * CHANNELS;
   localparam int NPIX = IN_WIDTH * IN_HEIGHT;
   localparam int PCW  = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [31:0] A_OUT  = 32'(FB);
   localparam logic [31:0] A_OVLD = 32'(FB + 1);
   localparam logic [31:0] A_BUSY = 32'(FB + 9);
   localparam logic [31:0] A_RST  = 32'(FB + 17);
   localparam logic [31:0] A_WBEG = 32'(FB + 25);
   localparam logic [31:0] A_WEND = 32'(FB + 25 + 2 * NUM_WEIGHTS);
   localparam logic [31:0] A_CNT  = 32'(CNT_ADDR);
   localparam logic [31:0] W_LAST = 32'(NUM_WEIGHTS - 1);
   localparam logic [4:0]  CH5    = 5'(CHANNELS);
   localparam logic [PCW-1:0] P_LAST = PCW'(NPIX - 1);

   logic [7:0]          srst_q, srst_d;
   logic [63:0]         wbuf_q, wbuf_d;
   logic [2:0]          wlane_q, wlane_d;
   logic [31:0]         widx_q, widx_d;
   logic                wdone_q, wdone_d;
   logic [127:0]        pbuf_q, pbuf_d;
   logic [4:0]          pcnt_q, pcnt_d;
   logic [PCW-1:0]      pix_cnt_q, pix_cnt_d;
   logic                busy_q, busy_d;
   logic                o_valid_q, o_valid_d;
   logic [OUT_BITS-1:0] o_data_q, o_data_d;
   logic [31:0]         cyc_q, cyc_d;

   logic [31:0]  wa, ra;
   logic         soft_act, wr_acc, srst_trig;
   logic         w_hit, in_hit, pop, first_pix, out_rd;
   logic [127:0] pb_tmp;
   logic [4:0]   pc_tmp;

   assign wa        = 32'(axi_wr_addr);
   assign ra        = 32'(axi_rd_addr);
   assign soft_act  = (srst_q != 8'd0);
   assign wr_acc    = axi_wr_en && (|axi_wr_strobe) && axi_wr_ready;
   assign srst_trig = wr_acc && (wa == A_RST) && axi_wr_data[0];
   assign w_hit     = wr_acc && (wa >= A_WBEG) && (wa < A_WEND) && !wdone_q;
   assign in_hit    = wr_acc && (wa < A_OUT) && wdone_q;
   assign pop       = pix_valid && pix_ready;
   assign first_pix = pop && (pix_cnt_q == '0);
   assign out_rd    = axi_rd_en && (ra == A_OUT);

   assign axi_wr_ready     = !soft_act && (wlane_q == 3'd0) && (pcnt_q <= 5'd8);
   assign model_rst_n      = rst_n && !soft_act;
   assign pix_valid        = (pcnt_q >= CH5);
   assign pix_data         = pbuf_q[8*CHANNELS-1:0];
   assign weight_wr_en     = (wlane_q != 3'd0);
   assign weight_wr_data   = wbuf_q[15:0];
   assign weight_wr_addr   = widx_q;
   assign weight_load_done = wdone_q;
   assign busy             = busy_q;
   assign o_valid          = o_valid_q;
   assign o_data           = o_data_q;

   // soft-reset pulse counter, the only state that survives soft reset
   always_comb begin
      srst_d = srst_q;
      if (srst_trig) srst_d = 8'(SOFT_RESET_CYCLES);
      else if (soft_act) srst_d = srst_q - 8'd1;
   end

   // weight emitter, pack buffer, frame tracking and cycle counter
   always_comb begin
      wbuf_d    = wbuf_q;
      wlane_d   = wlane_q;
      widx_d    = widx_q;
      wdone_d   = wdone_q;
      pix_cnt_d = pix_cnt_q;
      busy_d    = busy_q;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      cyc_d     = cyc_q;
      pb_tmp    = pop ? (pbuf_q >> (8 * CHANNELS)) : pbuf_q;
      pc_tmp    = pop ? (pcnt_q - CH5) : pcnt_q;

      if (weight_wr_en) begin
         wbuf_d  = wbuf_q >> 16;
         wlane_d = wlane_q - 3'd1;
         widx_d  = widx_q + 32'd1;
         if (widx_q == W_LAST) begin
            wlane_d = 3'd0;
            wdone_d = 1'b1;
         end
      end
      if (w_hit) begin
         wbuf_d  = axi_wr_data;
         wlane_d = 3'd4;
      end

      // bytes above the count are always zero, so OR-insert is safe
      if (in_hit) begin
         pb_tmp = pb_tmp | ({64'd0, axi_wr_data} << {pc_tmp, 3'b000});
         pc_tmp = pc_tmp + 5'd8;
      end
      pbuf_d = pb_tmp;
      pcnt_d = pc_tmp;

      if (pop) pix_cnt_d = (pix_cnt_q == P_LAST) ? '0 : pix_cnt_q + 1'b1;

      if (first_pix) o_valid_d = 1'b0;
      if (out_rd) o_valid_d = 1'b0;
      if (model_o_valid) begin
         o_valid_d = 1'b1;
         o_data_d  = model_o_data;
      end

      if (model_o_valid) busy_d = 1'b0;
      if (first_pix) busy_d = 1'b1;

      if (first_pix) cyc_d = 32'd0;
      else if (busy_q && (cyc_q != '1)) cyc_d = cyc_q + 32'd1;

      if (soft_act || srst_trig) begin
         wbuf_d    = '0;
         wlane_d   = '0;
         widx_d    = '0;
         wdone_d   = 1'b0;
         pbuf_d    = '0;
         pcnt_d    = '0;
         pix_cnt_d = '0;
         busy_d    = 1'b0;
         o_valid_d = 1'b0;
         o_data_d  = '0;
         cyc_d     = '0;
      end
   end

   // combinational register read port
   always_comb begin
      axi_rd_data = '0;
      unique case (1'b1)
         (ra == A_OUT):  axi_rd_data = 64'(o_data_q);
         (ra == A_OVLD): axi_rd_data = 64'(o_valid_q);
         (ra == A_BUSY): axi_rd_data = 64'(busy_q);
         (ra == A_CNT):  axi_rd_data = 64'(cyc_q);
         default: ;
      endcase
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srst_q    <= '0;
         wbuf_q    <= '0;
         wlane_q   <= '0;
         widx_q    <= '0;
         wdone_q   <= 1'b0;
         pbuf_q    <= '0;
         pcnt_q    <= '0;
         pix_cnt_q <= '0;
         busy_q    <= 1'b0;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         cyc_q     <= '0;
      end else begin
         srst_q    <= srst_d;
         wbuf_q    <= wbuf_d;
         wlane_q   <= wlane_d;
         widx_q    <= widx_d;
         wdone_q   <= wdone_d;
         pbuf_q    <= pbuf_d;
         pcnt_q    <= pcnt_d;
         pix_cnt_q <= pix_cnt_d;
         busy_q    <= busy_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         cyc_q     <= cyc_d;
      end
   end

endmodule

// File: tb/tb_tsr_host_bridge.sv
// tb_tsr_host_bridge: directed bench for tsr_host_bridge.
// 32x32x3 frame, 6 weights, 15-cycle soft reset.
module tb_tsr_host_bridge;

   localparam int AW     = 20;
   localparam int FB     = 32 * 32 * 3;
   localparam int A_OUT  = FB;
   localparam int A_OVLD = FB + 1;
   localparam int A_BUSY = FB + 9;
   localparam int A_RST  = FB + 17;
   localparam int A_WB   = FB + 25;
   localparam int A_CNT  = 'h9_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          axi_wr_en = 1'b0;
   logic [AW-1:0] axi_wr_addr = '0;
   logic [63:0]   axi_wr_data = '0;
   logic [7:0]    axi_wr_strobe = '0;
   logic          axi_wr_ready;
   logic          axi_rd_en = 1'b0;
   logic [AW-1:0] axi_rd_addr = '0;
   logic [63:0]   axi_rd_data;
   logic          model_rst_n;
   logic [23:0]   pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic [15:0]   weight_wr_data;
   logic [31:0]   weight_wr_addr;
   logic          weight_wr_en;
   logic          model_o_valid = 1'b0;
   logic [5:0]    model_o_data = '0;
   logic          o_valid;
   logic [5:0]    o_data;
   logic          busy;
   logic          weight_load_done;

   tsr_host_bridge #(
      .IN_WIDTH(32), .IN_HEIGHT(32), .CHANNELS(3), .NUM_WEIGHTS(6),
      .OUT_BITS(6), .SOFT_RESET_CYCLES(15), .AXI_ADDR_WIDTH(AW),
      .CNT_ADDR('h9_0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr),
      .axi_wr_data(axi_wr_data), .axi_wr_strobe(axi_wr_strobe),
      .axi_wr_ready(axi_wr_ready),
      .axi_rd_en(axi_rd_en), .axi_rd_addr(axi_rd_addr),
      .axi_rd_data(axi_rd_data),
      .model_rst_n(model_rst_n),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .weight_wr_data(weight_wr_data), .weight_wr_addr(weight_wr_addr),
      .weight_wr_en(weight_wr_en),
      .model_o_valid(model_o_valid), .model_o_data(model_o_data),
      .o_valid(o_valid), .o_data(o_data), .busy(busy),
      .weight_load_done(weight_load_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a;
      int d;
      int c;
   } wev_t;

   int          errs = 0;
   int          checks = 0;
   int          tcyc = 0;
   int          done_cyc = -1;
   logic        prev_done = 1'b0;
   wev_t        wq[$];
   logic [23:0] pq[$];

   always @(posedge clk) tcyc <= tcyc + 1;

   // record handshakes from stable mid-cycle values
   always @(negedge clk) begin
      if (weight_wr_en)
         wq.push_back(wev_t'{int'(weight_wr_addr), int'(weight_wr_data), tcyc});
      if (pix_valid && pix_ready) pq.push_back(pix_data);
      if (weight_load_done && !prev_done) done_cyc <= tcyc;
      prev_done <= weight_load_done;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [63:0] d, input logic [7:0] s);
      int n;
      n = 0;
      axi_wr_en     = 1'b1;
      axi_wr_addr   = AW'(a);
      axi_wr_data   = d;
      axi_wr_strobe = s;
      @(negedge clk);
      while (!axi_wr_ready && n < 3000) begin
         n++;
         @(negedge clk);
      end
      chk("wr_ready", axi_wr_ready, 1);
      @(posedge clk);
      #1;
      axi_wr_en     = 1'b0;
      axi_wr_strobe = '0;
   endtask

   task automatic rd(input int a, output logic [63:0] v);
      axi_rd_addr = AW'(a);
      @(negedge clk);
      v = axi_rd_data;
      @(posedge clk);
      #1;
   endtask

   logic [63:0] v, c1, c2;
   logic [23:0] pexp[5];
   logic [7:0]  b;
   int          w0, p0, lo, bad, n;
   int          wi[4];

   initial begin
      pexp = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A, 24'h0F0E0D};
      wi = '{1, 2, 3, 5};

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_model_rst_n", model_rst_n, 0);
      chk("rst_ready_in_rst", axi_wr_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_model_rst_n_rel", model_rst_n, 1);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_wdone", weight_load_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_wen", weight_wr_en, 0);
      tick();
      rd(A_OUT, v);
      chk("rst_rd_out", v, 0);

      // input before weights are loaded
      wr(0, 64'h1111_1111_1111_1111, 8'hFF);
      tick();
      @(negedge clk);
      chk("pre_wt_pix_valid", pix_valid, 0);
      tick();

      // weight load
      w0 = wq.size();
      wr(A_WB, 64'h0004_0003_0002_0001, 8'hFF);
      wr(A_WB + 8, 64'h0000_0000_0006_0005, 8'hFF);
      repeat (8) tick();
      chk("w_count", 64'(wq.size() - w0), 6);
      for (int i = 0; i < 6; i++) begin
         chk("w_addr", 64'(wq[w0+i].a), 64'(i));
         chk("w_data", 64'(wq[w0+i].d), 64'(i + 1));
      end
      for (int i = 0; i < 4; i++)
         chk("w_consec", 64'(wq[w0+wi[i]].c - wq[w0+wi[i]-1].c), 1);
      chk("w_done_lat", 64'(done_cyc - wq[w0+5].c), 1);
      chk("w_done", weight_load_done, 1);
      wr(A_WB + 16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      repeat (6) tick();
      chk("w_after_done", 64'(wq.size() - w0), 6);

      // pixel unpacking
      pix_ready = 1'b1;
      p0 = pq.size();
      wr(0, 64'h0807_0605_0403_0201, 8'hFF);
      wr(8, 64'h100F_0E0D_0C0B_0A09, 8'hFF);
      repeat (8) tick();
      chk("pix_count", 64'(pq.size() - p0), 5);
      for (int i = 0; i < 5; i++) chk("pix_data", pq[p0+i], pexp[i]);
      @(negedge clk);
      chk("pix_rem_valid", pix_valid, 0);
      chk("pix_busy", busy, 1);
      tick();

      // strobe zero on RESET does nothing
      wr(A_RST, 64'h1, 8'h00);
      lo = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (!model_rst_n) lo++;
      end
      chk("strb0_rst", 64'(lo), 0);
      tick();

      // soft reset mid-frame
      wr(A_RST, 64'h1, 8'h01);
      lo = 0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!model_rst_n) begin
            lo++;
            if (axi_wr_ready) bad++;
         end
      end
      chk("srst_len", 64'(lo), 15);
      chk("srst_ready_low", 64'(bad), 0);
      chk("srst_busy", busy, 0);
      chk("srst_pix_valid", pix_valid, 0);
      chk("srst_wdone", weight_load_done, 0);
      chk("srst_model_rst_n", model_rst_n, 1);
      tick();

      // reload weights
      wr(A_WB, 64'h0004_0003_0002_0001, 8'hFF);
      wr(A_WB + 8, 64'h0000_0000_0006_0005, 8'hFF);
      repeat (8) tick();
      chk("reload_done", weight_load_done, 1);
      chk("frame_busy_idle", busy, 0);

      // full frame
      p0 = pq.size();
      for (int i = 0; i < 384; i++) begin
         b = i[7:0];
         wr(i * 8, {8{b}}, 8'hFF);
      end
      n = 0;
      while ((pq.size() - p0) < 1024 && n < 500) begin
         tick();
         n++;
      end
      chk("frame_pix_count", 64'(pq.size() - p0), 1024);
      chk("frame_last_pix", pq[p0+1023], 24'h7F7F7F);
      chk("frame_busy", busy, 1);
      chk("frame_pix_valid", pix_valid, 0);
      repeat (50) tick();
      model_o_valid = 1'b1;
      model_o_data  = 6'h2A;
      tick();
      model_o_valid = 1'b0;
      model_o_data  = '0;
      @(negedge clk);
      chk("res_o_valid", o_valid, 1);
      chk("res_busy", busy, 0);
      chk("res_o_data", o_data, 6'h2A);
      tick();
      rd(A_OUT, v);
      chk("rd_out", v, 64'h2A);
      rd(A_OVLD, v);
      chk("rd_ovld", v, 1);
      rd(A_BUSY, v);
      chk("rd_busy", v, 0);
      rd(A_CNT, c1);
      chk("rd_cnt_ge50", 64'(c1 >= 50), 1);
      repeat (3) tick();
      rd(A_CNT, c2);
      chk("rd_cnt_hold", c2, c1);
      rd(A_OUT + 2, v);
      chk("rd_other", v, 0);
      axi_rd_addr = AW'(A_OUT);
      axi_rd_en   = 1'b1;
      tick();
      axi_rd_en   = 1'b0;
      @(negedge clk);
      chk("rd_clear_ovld", o_valid, 0);
      tick();

      // backpressure
      pix_ready = 1'b0;
      wr(0, 64'h0807_0605_0403_0201, 8'hFF);
      wr(8, 64'h100F_0E0D_0C0B_0A09, 8'hFF);
      @(negedge clk);
      chk("bp_ready_full", axi_wr_ready, 0);
      chk("bp_pix_valid", pix_valid, 1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         #1 pix_ready = 1'b1;
         @(posedge clk);
         #1 pix_ready = 1'b0;
         @(negedge clk);
         chk("bp_ready_pop", axi_wr_ready, 64'((16 - 3 * k) <= 8));
      end
      chk("bp_pix_data", pix_data, 24'h0C0B0A);
      chk("bp_busy", busy, 1);
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
